// File: rtl/rho_serpar_buffer.sv
// Share-interleaved serial/parallel buffer that applies the Romulus rho feedback as words stream through.
// Defining RHO_SERPAR_PAD_EN enables auto-padding of partial final blocks; the default build has no PAD state.
module rho_serpar_buffer #(
  parameter int D = 2,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic                 out_en,
  input  logic [W-1:0]         pdi_data,
  input  logic [$clog2(W/8):0] pdi_bytes,
  input  logic                 pdi_last,
  input  logic                 pdi_valid,
  output logic                 pdi_ready,
  output logic [W-1:0]         pdo_data,
  output logic                 pdo_valid,
  input  logic                 pdo_ready,
  input  logic                 load_core,
  input  logic [128*D-1:0]     data_core,
  output logic [128*D-1:0]     state,
  output logic                 blk_done
);
  localparam int NW = 128 / W;
  localparam int NT = NW * D;
  localparam int NB = W / 8;
  localparam int CW = $clog2(NT + 1);
  localparam int BW = $clog2(NB) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(NT - 1);
  localparam logic [CW-1:0] SHARES     = CW'(D);
  localparam logic [CW-1:0] SHARE_LAST = CW'(D - 1);

`ifdef RHO_SERPAR_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PAD, S_DONE} fsm_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_DONE} fsm_t;
`endif

  fsm_t          fsm_q, fsm_d;
  logic [W-1:0]  buf_q [NT];
  logic [W-1:0]  buf_d [NT];
  logic [W-1:0]  core_w [NT];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    len_q, len_d;
  logic          blk_done_q, blk_done_d;

  logic [W-1:0]  top, g_top, pdi_eff, ins_word;
  logic [CW-1:0] share_idx;
  logic          is_share0, is_share_last, xfer, shift_en;
  logic [BW-1:0] bytes_eff;
  logic [5:0]    len_sum;
  logic [4:0]    len_sat;

  assign top = buf_q[0];

  // Slot k*D+s carries word k of share s; both core ports use the same layout.
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    for (genvar gj = 0; gj < D; gj++) begin : g_share
      assign core_w[gi*D+gj] = data_core[128*(D-gj)-1-gi*W -: W];
      assign state[128*(D-gj)-1-gi*W -: W] = buf_q[gi*D+gj];
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_gfun
    assign g_top[8*gi +: 8] = {top[8*gi] ^ top[8*gi+7], top[8*gi+7 -: 7]};
  end

  assign pdo_data      = pdi_data ^ g_top;
  assign pdi_ready     = (fsm_q == S_ABSORB) && (!out_en || pdo_ready);
  assign pdo_valid     = (fsm_q == S_ABSORB) && pdi_valid && out_en;
  assign xfer          = pdi_valid && pdi_ready;
  assign blk_done      = blk_done_q;
  assign share_idx     = cnt_q % SHARES;
  assign is_share0     = (share_idx == '0);
  assign is_share_last = (share_idx == SHARE_LAST);
  assign len_sum       = {1'b0, len_q} + 6'(bytes_eff);
  assign len_sat       = (len_sum > 6'd16) ? 5'd16 : len_sum[4:0];

`ifdef RHO_SERPAR_PAD_EN
  localparam logic [CW-1:0] WORD_LAST = CW'(NW - 1);
  logic [CW-1:0] word_idx;
  logic [4:0]    pad_len;
  logic [W-1:0]  pad_word, pdi_sel;

  assign bytes_eff = pdi_bytes;
  assign word_idx  = cnt_q / SHARES;
  // A partial share-0 final word already carries its own byte count in len.
  assign pad_len   = (fsm_q == S_PAD) ? len_q : len_sat;
  assign pad_word  = (is_share0 && (word_idx == WORD_LAST)) ? {{(W-5){1'b0}}, pad_len} : '0;
  assign pdi_sel   = decrypt ? pdo_data : pdi_data;
  for (genvar gi = 0; gi < NB; gi++) begin : g_mask
    assign pdi_eff[W-1-8*gi -: 8] = (pdi_bytes > BW'(gi)) ? pdi_sel[W-1-8*gi -: 8]
                                                           : pad_word[W-1-8*gi -: 8];
  end
`else
  logic unused_bytes;
  assign unused_bytes = ^pdi_bytes;
  assign bytes_eff    = BW'(NB);
  assign pdi_eff      = decrypt ? pdo_data : pdi_data;
`endif

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    shift_en = 1'b0;
    ins_word = pdi_eff ^ top;
    for (int i = 0; i < NT; i++) buf_d[i] = buf_q[i];
    case (fsm_q)
      S_IDLE: begin
        if (load_core) begin
          for (int i = 0; i < NT; i++) buf_d[i] = core_w[i];
        end else if (start) begin
          fsm_d = S_ABSORB;
          cnt_d = '0;
          len_d = '0;
        end
      end
      S_ABSORB: begin
        if (xfer) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (is_share0) len_d = len_sat;
          if (cnt_q == CNT_LAST) begin
            fsm_d = S_DONE;
          end else if (is_share_last && pdi_last) begin
`ifdef RHO_SERPAR_PAD_EN
            fsm_d = S_PAD;
`else
            fsm_d = S_DONE;
`endif
          end
        end
      end
`ifdef RHO_SERPAR_PAD_EN
      S_PAD: begin
        shift_en = 1'b1;
        ins_word = pad_word ^ top;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) fsm_d = S_DONE;
      end
`endif
      S_DONE: begin
        fsm_d = S_IDLE;
        cnt_d = '0;
      end
      default: fsm_d = S_IDLE;
    endcase
    if (shift_en) begin
      for (int i = 0; i < NT - 1; i++) buf_d[i] = buf_q[i+1];
      buf_d[NT-1] = ins_word;
    end
    blk_done_d = (fsm_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      blk_done_q <= 1'b0;
      for (int i = 0; i < NT; i++) buf_q[i] <= '0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      blk_done_q <= blk_done_d;
      for (int i = 0; i < NT; i++) buf_q[i] <= buf_d[i];
    end
  end
endmodule

// File: tb/tb_rho_serpar_buffer.sv
// Directed bench for rho_serpar_buffer (D=2, W=32): rho feedback, handshake stalls, reset, load priority.
// The padding case is exercised when RHO_SERPAR_PAD_EN is defined, the early-last case otherwise.
module tb_rho_serpar_buffer;
  localparam int D = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start, decrypt, out_en, pdi_last, pdi_valid, pdo_ready, load_core;
  logic [W-1:0]   pdi_data, pdo_data;
  logic [2:0]     pdi_bytes;
  logic           pdi_ready, pdo_valid, blk_done;
  logic [255:0]   data_core, state;
  int             total = 0;
  int             bad = 0;

  localparam logic [255:0] CORE  = {32'h80000001, 32'h22222222, 32'h33333333, 32'h44444444,
                                    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [255:0] MID   = {32'h33333333, 32'h44444444, 32'h80000001, 32'h00000000,
                                    32'h77777777, 32'h88888888, 32'h44444444, 32'h55555555};
  localparam logic [255:0] FINAL = {32'h80000001, 32'h00000000, 32'h77777777, 32'h22222222,
                                    32'h44444444, 32'h55555555, 32'h22222222, 32'hFFFFFFFF};
  localparam logic [255:0] PADST = {32'h11223344, 32'hAA000000, 32'h00000000, 32'h00000005,
                                    32'h11223344, 32'hAA000000, 32'h00000000, 32'h00000000};
  localparam logic [255:0] EARLY = {32'h00000000, 32'h00000000, 32'h11223344, 32'hAABBCCDD,
                                    32'h00000000, 32'h00000000, 32'h11223344, 32'hAABBCCDD};
  localparam logic [255:0] CORE2 = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D,
                                    32'h0BADC0DE, 32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98};

  rho_serpar_buffer #(.D(D), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .out_en(out_en),
    .pdi_data(pdi_data), .pdi_bytes(pdi_bytes), .pdi_last(pdi_last), .pdi_valid(pdi_valid),
    .pdi_ready(pdi_ready), .pdo_data(pdo_data), .pdo_valid(pdo_valid), .pdo_ready(pdo_ready),
    .load_core(load_core), .data_core(data_core), .state(state), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [2:0] nb, input logic lst);
    pdi_data  = d;
    pdi_bytes = nb;
    pdi_last  = lst;
    pdi_valid = 1'b1;
    #1;
    $display("xfer pdi=%h bytes=%0d last=%0b ready=%0b pdo=%h", d, nb, lst, pdi_ready, pdo_data);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; out_en = 1'b0; pdi_last = 1'b0;
    pdi_valid = 1'b0; pdo_ready = 1'b0; load_core = 1'b0; pdi_data = '0;
    pdi_bytes = 3'd4; data_core = '0;
    tick; tick;
    chk("rst_ready", 256'(pdi_ready), 256'(0));
    chk("rst_pvalid", 256'(pdo_valid), 256'(0));
    chk("rst_done", 256'(blk_done), 256'(0));
    chk("rst_state", state, '0);
    rst = 1'b0;
    tick;

    // Encrypt block: G(0x80000001) = 0xC0000080, then a two-cycle output stall mid-block.
    data_core = CORE; load_core = 1'b1; tick; load_core = 1'b0;
    chk("load_state", state, CORE);
    start = 1'b1; out_en = 1'b1; pdo_ready = 1'b1; tick; start = 1'b0;
    put(32'h00000000, 3'd4, 1'b0);
    chk("enc_pdo", 256'(pdo_data), 256'(32'hC0000080));
    chk("enc_pvalid", 256'(pdo_valid), 256'(1));
    chk("enc_ready", 256'(pdi_ready), 256'(1));
    tick;
    chk("enc_ins", 256'(state[31:0]), 256'(32'h80000001));
    put(32'h11111111, 3'd4, 1'b0);
    chk("enc_pdo1", 256'(pdo_data), 256'(32'hBBBBBBBB));
    tick;
    put(32'h22222222, 3'd4, 1'b0); tick;
    put(32'h33333333, 3'd4, 1'b0); tick;
    pdo_ready = 1'b0;
    put(32'h44444444, 3'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_ready", 256'(pdi_ready), 256'(0));
      chk("stall_pvalid", 256'(pdo_valid), 256'(1));
      tick;
      chk("stall_state", state, MID);
    end
    pdo_ready = 1'b1;
    for (int t = 4; t < 8; t++) begin
      put(32'h11111111 * 32'(t), 3'd4, 1'b0);
      if (t == 7) chk("pre_done", 256'(blk_done), 256'(0));
      tick;
    end
    pdi_valid = 1'b0;
    chk("blk_done", 256'(blk_done), 256'(1));
    chk("done_ready", 256'(pdi_ready), 256'(0));
    chk("final_state", state, FINAL);
    tick;
    chk("done_pulse", 256'(blk_done), 256'(0));

    // Decrypt block, then absorb-only transfers, then reset at cnt=3.
    data_core = CORE; load_core = 1'b1; tick; load_core = 1'b0;
    decrypt = 1'b1; start = 1'b1; tick; start = 1'b0;
    put(32'hC0000080, 3'd4, 1'b0);
    chk("dec_pdo", 256'(pdo_data), 256'(32'h00000000));
    tick;
    chk("dec_ins", 256'(state[31:0]), 256'(32'h80000001));
    out_en = 1'b0; pdo_ready = 1'b0;
    put(32'h00000000, 3'd4, 1'b0);
    chk("ad_ready", 256'(pdi_ready), 256'(1));
    chk("ad_pvalid", 256'(pdo_valid), 256'(0));
    tick;
    chk("dec_ins1", 256'(state[31:0]), 256'(32'hFFFFFFFF));
    put(32'h00000000, 3'd4, 1'b0); tick;
    chk("dec_ins2", 256'(state[31:0]), 256'(32'h33333333));
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 256'(pdi_ready), 256'(0));
    chk("rst_mid_state", state, '0);
    pdi_valid = 1'b0; decrypt = 1'b0; out_en = 1'b1; pdo_ready = 1'b1;
    tick; rst = 1'b0; tick;
    chk("idle_ready", 256'(pdi_ready), 256'(0));

    // Short block on a zero buffer: word 1 carries one valid byte and pdi_last.
    start = 1'b1; tick; start = 1'b0;
    put(32'h11223344, 3'd4, 1'b0); tick;
    put(32'h11223344, 3'd4, 1'b0); tick;
    put(32'hAABBCCDD, 3'd1, 1'b0);
    chk("part_pdo", 256'(pdo_data), 256'(32'hAABBCCDD));
    tick;
    put(32'hAABBCCDD, 3'd1, 1'b1); tick;
`ifdef RHO_SERPAR_PAD_EN
    chk("pad_ready", 256'(pdi_ready), 256'(0));
    chk("pad_pvalid", 256'(pdo_valid), 256'(0));
    for (int i = 0; i < 4; i++) begin
      chk("pad_busy", 256'(blk_done), 256'(0));
      tick;
    end
    chk("pad_done", 256'(blk_done), 256'(1));
    chk("pad_state", state, PADST);
`else
    chk("early_done", 256'(blk_done), 256'(1));
    chk("early_state", state, EARLY);
`endif
    pdi_valid = 1'b0; pdi_last = 1'b0;
    tick;

    // load_core wins over a simultaneous start.
    out_en = 1'b0; data_core = CORE2; load_core = 1'b1; start = 1'b1;
    tick; load_core = 1'b0; start = 1'b0;
    chk("ls_state", state, CORE2);
    chk("ls_ready", 256'(pdi_ready), 256'(0));
    pdi_valid = 1'b1; pdi_data = 32'h5A5A5A5A;
    tick;
    chk("ls_hold", state, CORE2);
    chk("ls_ready2", 256'(pdi_ready), 256'(0));
    pdi_valid = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
